// File: rtl/regio_arbiter_if.sv
// regio_arbiter_if: request/grant bundle and muxed regIO bus.
// master = requester/regIO side, slave = arbiter side.
interface regio_arbiter_if;
    logic [2:0]  req;
    logic [23:0] req_offset;
    logic [2:0]  req_length;
    logic [2:0]  req_wr;
    logic [47:0] req_wdata;
    logic [2:0]  req_newcmd;
    logic [2:0]  req_dummy;
    logic [3:0]  state;
    logic [2:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  offset;
    logic        length;
    logic        WR;
    logic [15:0] writeData;
    logic        NewCommand;
    logic        Dummy_Read;
    logic        wdog_err;

    modport master (
        output req, req_offset, req_length, req_wr,
        output req_wdata, req_newcmd, req_dummy, state,
        input  gnt, owner, busy, offset, length, WR,
        input  writeData, NewCommand, Dummy_Read, wdog_err
    );

    modport slave (
        input  req, req_offset, req_length, req_wr,
        input  req_wdata, req_newcmd, req_dummy, state,
        output gnt, owner, busy, offset, length, WR,
        output writeData, NewCommand, Dummy_Read, wdog_err
    );
endinterface

// File: rtl/regio_arbiter.sv
// regio_arbiter: three-way owner arbiter in front of the regIO engine.
// Optional grant watchdog enabled by macro REGIO_ARB_WATCHDOG_EN.
module regio_arbiter #(
    parameter int         WDOG_LIMIT = 50000,
    parameter logic [3:0] WAIT_STATE = 4'b1001
) (
    input  logic           sysclk,
    input  logic           reset,
    regio_arbiter_if.slave io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    localparam logic [1:0] NONE = 2'b11;

    fsm_t        fsm_q, fsm_d;
    logic [1:0]  own_q, own_d;
    logic        last_q, last_d;
    logic [2:0]  mask_q;
    logic [2:0]  elig;
    logic [1:0]  win;
    logic        wdog_hit;

    logic        cur_req;
    logic [7:0]  cur_off;
    logic        cur_len;
    logic        cur_wr;
    logic [15:0] cur_wd;
    logic        cur_new;
    logic        cur_dmy;

    logic [7:0]  hold_off;
    logic        hold_len;
    logic        hold_wr;
    logic [15:0] hold_wd;
    logic        hold_dmy;

    assign elig = io.req & ~mask_q;

    // Pick a winner: init always first, rx/tx alternate on contention
    always_comb begin
        win = NONE;
        priority case (1'b1)
            elig[0]:            win = 2'd0;
            elig[1] && elig[2]: win = last_q ? 2'd1 : 2'd2;
            elig[1]:            win = 2'd1;
            elig[2]:            win = 2'd2;
            default:            win = NONE;
        endcase
    end

    // Select the current owner's request fields
    always_comb begin
        cur_req = 1'b0;
        cur_off = '0;
        cur_len = 1'b0;
        cur_wr  = 1'b0;
        cur_wd  = '0;
        cur_new = 1'b0;
        cur_dmy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (own_q == 2'(i)) begin
                cur_req = io.req[i];
                cur_off = io.req_offset[8*i +: 8];
                cur_len = io.req_length[i];
                cur_wr  = io.req_wr[i];
                cur_wd  = io.req_wdata[16*i +: 16];
                cur_new = io.req_newcmd[i];
                cur_dmy = io.req_dummy[i];
            end
        end
    end

`ifdef REGIO_ARB_WATCHDOG_EN
    localparam logic [15:0] LIMIT_M1 = 16'(WDOG_LIMIT - 1);

    logic [15:0] cnt_q;

    // Count cycles in OWN; zero outside so every grant starts fresh
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (fsm_q != OWN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign wdog_hit    = (fsm_q == OWN) && (cnt_q == LIMIT_M1);
    assign io.wdog_err = wdog_hit;

    // Block a timed-out requester until it lets go of req
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wdog_hit && own_q == 2'(i)) begin
                    mask_q[i] <= 1'b1;
                end else if (!io.req[i]) begin
                    mask_q[i] <= 1'b0;
                end
            end
        end
    end
`else
    logic [15:0] unused_wdog_limit;

    assign unused_wdog_limit = 16'(WDOG_LIMIT);
    assign wdog_hit          = 1'b0;
    assign mask_q            = '0;
    assign io.wdog_err       = 1'b0;
`endif

    // Next state, owner and round-robin bookkeeping
    always_comb begin
        fsm_d  = fsm_q;
        own_d  = own_q;
        last_d = last_q;
        unique case (fsm_q)
            IDLE: begin
                if (win != NONE) begin
                    fsm_d = OWN;
                    own_d = win;
                    if (win != 2'd0) begin
                        last_d = (win == 2'd2);
                    end
                end
            end
            OWN: begin
                if (wdog_hit || !cur_req) begin
                    fsm_d = DRAIN;
                end
            end
            DRAIN: begin
                if (io.state == WAIT_STATE) begin
                    fsm_d = IDLE;
                    own_d = NONE;
                end
            end
            default: begin
                fsm_d = IDLE;
                own_d = NONE;
            end
        endcase
    end

    // FSM, owner and last-served registers
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            fsm_q  <= IDLE;
            own_q  <= NONE;
            last_q <= 1'b1;
        end else begin
            fsm_q  <= fsm_d;
            own_q  <= own_d;
            last_q <= last_d;
        end
    end

    // Snapshot owner fields so DRAIN keeps them after req drops
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            hold_off <= '0;
            hold_len <= 1'b0;
            hold_wr  <= 1'b0;
            hold_wd  <= '0;
            hold_dmy <= 1'b0;
        end else if (fsm_q == OWN) begin
            hold_off <= cur_off;
            hold_len <= cur_len;
            hold_wr  <= cur_wr;
            hold_wd  <= cur_wd;
            hold_dmy <= cur_dmy;
        end
    end

    assign io.owner = own_q;
    assign io.busy  = (fsm_q != IDLE);

    // Drive the regIO bus from owner, snapshot or idle zeros
    always_comb begin
        io.gnt        = '0;
        io.offset     = '0;
        io.length     = 1'b0;
        io.WR         = 1'b0;
        io.writeData  = 16'h0000;
        io.NewCommand = 1'b0;
        io.Dummy_Read = 1'b0;
        unique case (fsm_q)
            OWN: begin
                io.gnt        = 3'b001 << own_q;
                io.offset     = cur_off;
                io.length     = cur_len;
                io.WR         = cur_wr;
                io.writeData  = cur_wd;
                io.NewCommand = cur_new;
                io.Dummy_Read = cur_dmy;
            end
            DRAIN: begin
                io.offset     = hold_off;
                io.length     = hold_len;
                io.WR         = hold_wr;
                io.writeData  = hold_wd;
                io.Dummy_Read = hold_dmy;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_regio_arbiter.sv
// tb_regio_arbiter: scoreboard bench for regio_arbiter.
// Watchdog scenario runs when REGIO_ARB_WATCHDOG_EN is defined.
module tb_regio_arbiter;

    localparam logic [3:0] WAITS = 4'b1001;
    localparam logic [3:0] READ1 = 4'b0011;

    logic sysclk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [23:0] offs = {8'h42, 8'h21, 8'h90};
    logic [47:0] wdat = {16'h2222, 16'h1111, 16'h6000};

    regio_arbiter_if io();

    regio_arbiter #(
        .WDOG_LIMIT(8),
        .WAIT_STATE(WAITS)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .io    (io)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [2:0]  g;
        logic [1:0]  o;
        logic [7:0]  off;
        logic [15:0] wd;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] prev_gnt = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #2;
    endtask

    task automatic push(input int i);
        exp_t e;
        e.g   = 3'b001 << i;
        e.o   = 2'(i);
        e.off = offs[8*i +: 8];
        e.wd  = wdat[16*i +: 16];
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (io.busy && n < 30) begin
            step(1);
            n++;
        end
        chk("idle_timeout", io.busy, 0);
    endtask

    // Compare each new grant against the oldest expected one
    always @(negedge sysclk) begin
        if (io.gnt != 3'b000 && prev_gnt == 3'b000) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", io.gnt, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_gnt", io.gnt, e.g);
                chk("sb_owner", io.owner, e.o);
                chk("sb_offset", io.offset, e.off);
                chk("sb_wdata", io.writeData, e.wd);
            end
        end
        prev_gnt = io.gnt;
    end

    initial begin
        int hit;
        int pulses;
        reset         = 1'b0;
        io.req        = 3'b000;
        io.req_offset = offs;
        io.req_length = 3'b010;
        io.req_wr     = 3'b011;
        io.req_wdata  = wdat;
        io.req_newcmd = 3'b111;
        io.req_dummy  = 3'b100;
        io.state      = 4'b0000;
        #12;
        chk("rst_gnt", io.gnt, 0);
        chk("rst_owner", io.owner, 3);
        chk("rst_busy", io.busy, 0);
        chk("rst_wdog", io.wdog_err, 0);
        chk("rst_offset", io.offset, 0);
        chk("rst_wdata", io.writeData, 0);
        reset = 1'b1;
        step(1);

        io.req = 3'b110;
        push(1);
        step(1);
        chk("lat_rx_gnt", io.gnt, 3'b010);
        chk("rx_len", io.length, 1);
        chk("rx_newcmd", io.NewCommand, 1);
        io.state = READ1;
        io.req   = 3'b100;
        push(2);
        step(1);
        chk("drain_gnt", io.gnt, 0);
        chk("drain_newcmd", io.NewCommand, 0);
        chk("drain_off_hold", io.offset, 8'h21);
        chk("drain_wr_hold", io.WR, 1);
        step(2);
        chk("drain_wait", io.busy, 1);
        io.state = WAITS;
        step(1);
        chk("idle_no_grant", io.gnt, 0);
        chk("idle_owner", io.owner, 3);
        step(1);
        chk("tx_gnt", io.gnt, 3'b100);
        chk("tx_dummy", io.Dummy_Read, 1);
        io.req = 3'b000;
        wait_idle();

        io.state = READ1;
        io.req   = 3'b111;
        push(0);
        push(1);
        step(1);
        chk("all_gnt", io.gnt, 3'b001);
        chk("all_owner", io.owner, 0);
        chk("all_off", io.offset, 8'h90);
        chk("all_wd", io.writeData, 16'h6000);
        io.req_wdata[31:16] = 16'hdead;
        step(1);
        chk("ignore_other", io.writeData, 16'h6000);
        io.req_wdata = wdat;
        io.req = 3'b110;
        step(1);
        chk("drain0_owner", io.owner, 0);
        step(3);
        chk("drain0_busy", io.busy, 1);
        io.state = WAITS;
        step(2);
        chk("rr_rx_gnt", io.gnt, 3'b010);
        io.req = 3'b111;
        step(3);
        chk("no_preempt", io.gnt, 3'b010);
        push(0);
        io.req = 3'b101;
        step(3);
        chk("req0_next", io.gnt, 3'b001);
        push(2);
        io.req = 3'b100;
        step(3);
        chk("tx_next", io.gnt, 3'b100);
        io.req = 3'b000;
        wait_idle();

        io.req = 3'b010;
        push(1);
        step(1);
        io.req = 3'b000;
        chk("short_own", io.gnt, 3'b010);
        step(1);
        chk("short_drain", io.gnt, 0);
        chk("short_busy", io.busy, 1);
        wait_idle();

        io.req = 3'b010;
        push(1);
        step(2);
        chk("pre_rst_gnt", io.gnt, 3'b010);
        #1 reset = 1'b0;
        #1;
        chk("arst_gnt", io.gnt, 0);
        chk("arst_owner", io.owner, 3);
        chk("arst_busy", io.busy, 0);
        chk("arst_offset", io.offset, 0);
        chk("arst_newcmd", io.NewCommand, 0);
        io.req = 3'b000;
        step(1);
        reset  = 1'b1;
        io.req = 3'b100;
        push(2);
        step(1);
        chk("post_rst_tx", io.gnt, 3'b100);
        io.req = 3'b000;
        wait_idle();

`ifdef REGIO_ARB_WATCHDOG_EN
        io.req = 3'b010;
        push(1);
        step(1);
        hit    = 0;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            if (io.wdog_err) begin
                pulses++;
                if (hit == 0) hit = c;
            end
            if (c < 20) step(1);
        end
        chk("wdog_cycle", hit, 8);
        chk("wdog_pulses", pulses, 1);
        chk("masked_gnt", io.gnt, 0);
        chk("masked_busy", io.busy, 0);
        io.req = 3'b000;
        step(1);
        io.req = 3'b010;
        push(1);
        step(1);
        chk("regrant_rx", io.gnt, 3'b010);
        io.req = 3'b000;
        wait_idle();
`endif

        step(2);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
